// File: rtl/barrido_display_4dig.sv
// Four-digit common-anode scan driver: frame-synchronous shadow register, per-slot blanking.
// Optional LEADING_ZERO_BLANK_EN keeps leading zero digits (other than digit 0) dark.
module barrido_display_4dig #(
  parameter int REFRESH_DIV      = 50000,
  parameter int BLANK_CYCLES     = 2,
  parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] valor,
  input  logic        load,
  output logic [3:0]  Binario,
  output logic [3:0]  anodos,
  output logic [1:0]  digito_idx,
  output logic        frame_start
);
  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = $clog2(BLANK_CYCLES + 2);
  localparam logic [PW-1:0] PMAX   = PW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLOAD  = BW'(BLANK_CYCLES);
  localparam logic [3:0]    AN_OFF = ANODE_ACTIVE_LOW ? 4'hF : 4'h0;

  typedef enum logic [1:0] {BLANCO, MOSTRAR, DETENIDO} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] blank_q, blank_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d, pend_q, pend_d;
  logic          pv_q, pv_d, fs_q, fs_d;
  logic [3:0]    bin_q, bin_d, an_q, an_d, on_d;
  logic          tick, wrap;

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    blank_d  = blank_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    pv_d     = pv_q;
    fs_d     = 1'b0;
    bin_d    = bin_q;
    tick     = enable && (presc_q == PMAX);
    wrap     = tick && (idx_q == 2'd3);

    // A load on the wrap edge bypasses pending and goes straight to shadow.
    if (load && !wrap) begin
      pend_d = valor;
      pv_d   = 1'b1;
    end

    if (!enable) begin
      state_d = DETENIDO;
    end else begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick || state_q == DETENIDO) begin
        if (BLANK_CYCLES == 0) state_d = MOSTRAR;
        else begin
          state_d = BLANCO;
          blank_d = BLOAD;
        end
      end else if (state_q == BLANCO) begin
        if (blank_q <= BW'(1)) state_d = MOSTRAR;
        else                   blank_d = blank_q - 1'b1;
      end
      if (tick) begin
        idx_d = idx_q + 2'd1;
        if (wrap) begin
          if (load) begin
            shadow_d = valor;
            pv_d     = 1'b0;
            fs_d     = 1'b1;
          end else if (pv_q) begin
            shadow_d = pend_q;
            pv_d     = 1'b0;
            fs_d     = 1'b1;
          end
        end
        bin_d = shadow_d[{idx_d, 2'b00} +: 4];
      end
    end

    on_d = (state_d == MOSTRAR) ? (4'b0001 << idx_d) : 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx_d != 2'd0 && (shadow_d >> {idx_d, 2'b00}) == 16'h0) on_d = 4'b0000;
`endif
    an_d = on_d ^ AN_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BLANCO;
      presc_q  <= '0;
      blank_q  <= BLOAD;
      idx_q    <= 2'd0;
      shadow_q <= 16'h0;
      pend_q   <= 16'h0;
      pv_q     <= 1'b0;
      fs_q     <= 1'b0;
      bin_q    <= 4'h0;
      an_q     <= AN_OFF;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      blank_q  <= blank_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      pv_q     <= pv_d;
      fs_q     <= fs_d;
      bin_q    <= bin_d;
      an_q     <= an_d;
    end
  end

  assign Binario     = bin_q;
  assign anodos      = an_q;
  assign digito_idx  = idx_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_barrido_display_4dig.sv
// Bench for barrido_display_4dig: constant vector table, corner sequences, random run vs model.
module tb_barrido_display_4dig;
  localparam int R = 4;
  localparam int B = 1;

  logic        clk, rst_n, enable, load, frame_start;
  logic [15:0] valor;
  logic [3:0]  Binario, anodos;
  logic [1:0]  digito_idx;

  barrido_display_4dig #(.REFRESH_DIV(R), .BLANK_CYCLES(B), .ANODE_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .valor(valor), .load(load),
    .Binario(Binario), .anodos(anodos), .digito_idx(digito_idx), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nbad = 0;

  // Reference: slot position, blank remaining and frame values as plain integers
  int          m_presc, m_idx, m_blank;
  bit          m_stop, m_pv, m_fs;
  logic [15:0] m_sh, m_pend;

  typedef struct {
    bit          en;
    bit          ld;
    logic [15:0] val;
    logic [3:0]  an;
    logic [3:0]  bin;
    logic [1:0]  idx;
    bit          fs;
  } vec_t;
  vec_t tab[32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_presc = 0; m_idx = 0; m_blank = B; m_stop = 0; m_pv = 0; m_fs = 0;
    m_sh = 16'h0; m_pend = 16'h0;
  endtask

  task automatic model_step(input bit en, input bit ld, input logic [15:0] v);
    m_fs = 0;
    if (en) begin
      if (m_presc == R - 1) begin
        m_presc = 0;
        if (m_idx == 3) begin
          if (ld) begin m_sh = v; m_pv = 0; m_fs = 1; end
          else if (m_pv) begin m_sh = m_pend; m_pv = 0; m_fs = 1; end
        end else if (ld) begin m_pend = v; m_pv = 1; end
        m_idx   = (m_idx + 1) % 4;
        m_blank = B;
      end else begin
        m_presc++;
        if (ld) begin m_pend = v; m_pv = 1; end
        m_blank = m_stop ? B : (m_blank > 0 ? m_blank - 1 : 0);
      end
      m_stop = 0;
    end else begin
      m_stop = 1;
      if (ld) begin m_pend = v; m_pv = 1; end
    end
  endtask

  function automatic logic [10:0] model_out();
    logic [3:0]  an, bin;
    logic [15:0] hi;
    hi  = m_sh >> (4 * m_idx);
    bin = hi[3:0];
    an  = 4'hF;
    if (!m_stop && m_blank == 0) an = ~(4'b0001 << m_idx);
`ifdef LEADING_ZERO_BLANK_EN
    if (m_idx > 0 && hi == 16'h0) an = 4'hF;
`endif
    return {an, bin, 2'(m_idx), m_fs};
  endfunction

  task automatic step(input bit en, input bit ld, input logic [15:0] v);
    enable = en; load = ld; valor = v;
    @(posedge clk);
    model_step(en, ld, v);
    #1;
    chk("model {an,bin,idx,fs}", {21'h0, anodos, Binario, digito_idx, frame_start}, {21'h0, model_out()});
    load = 1'b0;
  endtask

  initial begin
    logic [15:0] nv;
    logic [3:0]  held;
    int          guard, nfs;
    rst_n = 1'b0; enable = 1'b0; load = 1'b0; valor = 16'h0;
    model_reset();

    // Table: 1A3F becomes visible only from the first wrap (edge 16) onward
    nv = 16'h1A3F;
    for (int k = 1; k < 32; k++) begin
      tab[k].en  = 1'b1;
      tab[k].ld  = (k == 1);
      tab[k].val = (k == 1) ? nv : 16'h0;
      tab[k].idx = 2'((k / 4) % 4);
      tab[k].bin = (k >= 16) ? nv[4 * ((k / 4) % 4) +: 4] : 4'h0;
      tab[k].an  = (k % 4 == 0) ? 4'hF : ~(4'b0001 << ((k / 4) % 4));
`ifdef LEADING_ZERO_BLANK_EN
      if (k < 16 && (k / 4) % 4 != 0) tab[k].an = 4'hF;
`endif
      tab[k].fs = (k == 16);
    end

    #12;
    chk("reset_state", {anodos, Binario, digito_idx, frame_start}, {4'hF, 4'h0, 2'd0, 1'b0});
    rst_n = 1'b1;
    for (int k = 1; k < 32; k++) begin
      step(tab[k].en, tab[k].ld, tab[k].val);
      chk($sformatf("table[%0d]", k), {anodos, Binario, digito_idx, frame_start},
          {tab[k].an, tab[k].bin, tab[k].idx, tab[k].fs});
    end

    // Load coalescing: 1111 then 2222 inside one frame -> single frame of 2s
    step(1, 0, 16'h0);
    step(1, 1, 16'h1111);
    step(1, 1, 16'h2222);
    nfs = 0;
    for (int k = 35; k <= 64; k++) begin
      step(1, 0, 16'h0);
      if (frame_start) nfs++;
      if (k > 48 && k < 64 && anodos != 4'hF) chk("coalesce_digit", Binario, 4'h2);
    end
    chk("coalesce_fs_count", nfs, 1);

    // Enable hold on digit 2
    guard = 0;
    while (!(digito_idx == 2'd2 && anodos == 4'hB) && guard < 40) begin step(1, 0, 16'h0); guard++; end
    chk("hold_reach", guard < 40, 1);
    held = Binario;
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 16'h0);
      chk("hold_an", anodos, 4'hF);
      chk("hold_idx", digito_idx, 2'd2);
      chk("hold_bin", Binario, held);
    end
    step(1, 0, 16'h0);
    chk("resume_blank", anodos, 4'hF);
    step(1, 0, 16'h0);
    chk("resume_show", {anodos, digito_idx}, {4'hB, 2'd2});

    // Bypass load on the wrap edge
    guard = 0;
    while (!(m_presc == R - 1 && m_idx == 3) && guard < 40) begin step(1, 0, 16'h0); guard++; end
    chk("bypass_reach", guard < 40, 1);
    step(1, 1, 16'h000C);
    chk("bypass_fs_bin", {frame_start, Binario}, {1'b1, 4'hC});
    for (int k = 0; k < 16; k++) step(1, 0, 16'h0);

    // Async reset mid-MOSTRAR on digit 3 with nonzero digit
    step(1, 1, 16'hF000);
    guard = 0;
    while (!(digito_idx == 2'd3 && anodos == 4'h7 && Binario == 4'hF) && guard < 60) begin
      step(1, 0, 16'h0); guard++;
    end
    chk("areset_reach", guard < 60, 1);
    #2 rst_n = 1'b0;
    #1 chk("areset_now", {anodos, Binario, digito_idx, frame_start}, {4'hF, 4'h0, 2'd0, 1'b0});
    @(posedge clk); #2;
    chk("areset_hold", {anodos, Binario, digito_idx}, {4'hF, 4'h0, 2'd0});
    rst_n = 1'b1;
    model_reset();

    // Random traffic against the model
    for (int k = 0; k < 600; k++)
      step($urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0, 16'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
